sw_align_param: RTL and testbench
=================================

// Module: sw_align_param
// PURPOSE
//  Parametrised Smith-Waterman local-alignment engine with affine gaps.
//  Query S (len_s <= NPE symbols) is loaded into a linear systolic array of NPE cells.
//  Target T (len_t symbols) then streams through the array under valid/ready.
//  Reports the best local score and the target index where it ends.
//  Successor to the fixed 128-cell sw core: runtime lengths, runtime scoring and backpressure.
// PARAMETERS
//  NPE   128  number of PE cells (max query length)
//  SYMW  2    symbol width in bits
//  SW    12   score width (unsigned, saturating)
//  PW    4    width of each scoring/penalty input
//  LTW   10   target length/index width (max len_t = 2^LTW-1)
// PORTS
//  clk        in   1                   clock, rising edge
//  reset      in   1                   asynchronous, active-high
//  start      in   1                   1-cycle request; latches len_*, scoring inputs
//  len_s      in   $clog2(NPE+1)       query length
//  len_t      in   LTW                 target length
//  match      in   PW                  added on symbol equality
//  mismatch   in   PW                  subtracted on inequality
//  gap_open   in   PW                  penalty for opening a gap (first gap symbol)
//  gap_ext    in   PW                  penalty per extension symbol
//  in_valid   in   1                   in_data valid
//  in_ready   out  1                   engine accepts in_data this cycle
//  in_data    in   SYMW                S symbols first (len_s), then T symbols (len_t)
//  busy       out  1                   high from the cycle after start until done
//  done       out  1                   1-cycle pulse, results valid
//  err        out  1                   set with done on an illegal config
//  max_score  out  SW                  best local score
//  max_end_t  out  LTW                 0-based T index of best score
// BEHAVIOUR
//  Reset: state IDLE; in_ready, busy, done, err = 0; max_score, max_end_t = 0; all PE regs cleared.
//  Reset mid-operation aborts immediately with no done. Held inputs are ignored.
//  FSM states:
//   IDLE: start -> LOAD_S.
//     Exception: if len_s==0, len_s>NPE or len_t==0, go to DONE with err=1 and results 0.
//     start is ignored in every other state.
//   LOAD_S: in_ready=1. Each handshake (in_valid&in_ready) shifts one S symbol in.
//     After the len_s-th handshake -> STREAM_T. Cells >= len_s are disabled.
//   STREAM_T: in_ready=1. Each handshake injects one T symbol plus a valid tag into cell 0.
//     A non-handshake cycle injects a bubble; bubbles carry no update.
//     After the len_t-th handshake -> DRAIN.
//   DRAIN: in_ready=0. Lasts exactly len_s+1 cycles -> DONE.
//   DONE: done=1 for one cycle; busy=0 -> IDLE.
//     done therefore rises len_s+2 cycles after the cycle of the last T handshake.
//  Cell i, for valid T symbol j, computes:
//   E = max(H[i][j-1]-gap_open, E[i][j-1]-gap_ext)
//   F = max(H[i-1][j]-gap_open, F[i-1][j]-gap_ext)
//   H = max(0, E, F, H[i-1][j-1] + (S[i]==T[j] ? match : -mismatch))
//   Boundary values H, E, F (row -1 / column -1) are 0.
//  Arithmetic: signed internally at SW+2 bits. Negative results clamp to 0.
//   Results above 2^SW-1 saturate to 2^SW-1.
//  Running max: update only when H > max (strictly greater).
//   On an equal score, keep the smaller j. Same j in multiple cells: no change.
//  max_score and max_end_t update at DONE and hold until the next start is accepted.
//  Each new start clears the internal running max.
// TESTING
//  1. match=2 mismatch=1 gap_open=2 gap_ext=1; S=0,1,2,3; T=0,1,2,3, in_valid always high
//     -> max_score=8, max_end_t=3, err=0; done 6 cycles after the last T handshake.
//  2. S=0,0,0,0; T=1,1,1,1 -> max_score=0, max_end_t=0, err=0.
//  3. start with len_s=0 (then len_s=NPE+1, then len_t=0)
//     -> next cycle done=1, err=1, in_ready never high.
//  4. Repeat case 1 with in_valid toggling 1,0,1,0 -> identical results;
//     done 6 cycles after the last T handshake.
//  5. SW=6, NPE=64: S = 40 zeros, T = 40 zeros, match=2 -> max_score=63 (saturated).
//     With strictly-greater update, max_end_t = first column reaching 63.
//  6. Reset asserted during STREAM_T, then case 1 rerun
//     -> all outputs 0 during reset; rerun result matches case 1.
//  7. start held high in STREAM_T -> ignored; result unchanged.

Source files
------------

// File: rtl/sw_align_param.sv
// Smith-Waterman local aligner (affine gaps) on a linear systolic array of NPE cells.
// Latency: done rises len_s+2 cycles after the cycle of the last target handshake.
// Backpressure: in_ready high only while loading query / streaming target; idle cycles become bubbles.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start                 1-cycle request; latches len_s, len_t and the four scoring inputs
//   len_s, len_t          query length (1..NPE) and target length (1..2^LTW-1)
//   match, mismatch       added on equal symbols / subtracted on unequal symbols
//   gap_open, gap_ext     penalty for the first gap symbol / each further gap symbol
//   in_valid/in_ready     symbol handshake; in_data carries len_s query then len_t target symbols
//   busy, done, err       run in progress, 1-cycle completion pulse, illegal-config flag with done
//   max_score, max_end_t  best local score and the 0-based target index where it ends
module sw_align_param #(
   parameter int NPE  = 128,
   parameter int SYMW = 2,
   parameter int SW   = 12,
   parameter int PW   = 4,
   parameter int LTW  = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [$clog2(NPE+1)-1:0]   len_s,
   input  logic [LTW-1:0]             len_t,
   input  logic [PW-1:0]              match,
   input  logic [PW-1:0]              mismatch,
   input  logic [PW-1:0]              gap_open,
   input  logic [PW-1:0]              gap_ext,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SYMW-1:0]            in_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [SW-1:0]              max_score,
   output logic [LTW-1:0]             max_end_t
);

   localparam int LSW = $clog2(NPE+1);
   // Internal signed width: room for a saturated score plus a penalty, and a sign bit.
   localparam int IW  = SW + 2;

   typedef enum logic [2:0] {IDLE, LOAD_S, STREAM_T, DRAIN, DONE} state_t;

   state_t state, state_nx;

   logic [LSW-1:0] len_s_q;
   logic [LTW-1:0] len_t_q;
   logic [PW-1:0]  match_q, mismatch_q, gap_open_q, gap_ext_q;
   logic [LSW-1:0] s_cnt;
   logic [LTW-1:0] t_cnt;
   logic [LSW-1:0] d_cnt;
   logic           err_q;
   logic [SW-1:0]  best;
   logic [LTW-1:0] best_j;
   logic [LTW-1:0] col_cnt;

   logic           hs, clr, cfg_bad, inj_vld, s_we;
   logic [LSW-1:0] last_idx;
   logic           tap_vld;
   logic [SW-1:0]  tap_m;
   logic signed [IW-1:0] mat_s, mis_s, gop_s, gex_s;

   logic            vld_bus [NPE];
   logic [SYMW-1:0] sym_bus [NPE];
   logic [SW-1:0]   h_bus   [NPE];
   logic [SW-1:0]   f_bus   [NPE];
   logic [SW-1:0]   m_bus   [NPE];

   function automatic logic signed [IW-1:0] ext(input logic [SW-1:0] v);
      return $signed({2'b00, v});
   endfunction

   function automatic logic signed [IW-1:0] pext(input logic [PW-1:0] p);
      return $signed({{(IW-PW){1'b0}}, p});
   endfunction

   function automatic logic signed [IW-1:0] smax(input logic signed [IW-1:0] a,
                                                 input logic signed [IW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [SW-1:0] umax(input logic [SW-1:0] a, input logic [SW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Negative -> 0, anything above 2^SW-1 -> 2^SW-1.
   function automatic logic [SW-1:0] clip(input logic signed [IW-1:0] v);
      if (v[IW-1])
         return '0;
      else if (|v[IW-2:SW])
         return '1;
      else
         return v[SW-1:0];
   endfunction

   assign in_ready = (state == LOAD_S) || (state == STREAM_T);
   assign busy     = (state == LOAD_S) || (state == STREAM_T) || (state == DRAIN);
   assign done     = (state == DONE);
   assign err      = done & err_q;

   assign hs       = in_valid & in_ready;
   assign clr      = (state == IDLE) & start;
   assign cfg_bad  = (len_s == '0) || (len_s > LSW'(NPE)) || (len_t == '0);
   assign inj_vld  = (state == STREAM_T) & in_valid;
   assign s_we     = (state == LOAD_S) & hs;
   assign last_idx = len_s_q - LSW'(1);

   assign mat_s = pext(match_q);
   assign mis_s = pext(mismatch_q);
   assign gop_s = pext(gap_open_q);
   assign gex_s = pext(gap_ext_q);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start) state_nx = cfg_bad ? DONE : LOAD_S;
         LOAD_S:   if (hs && (s_cnt == last_idx)) state_nx = STREAM_T;
         STREAM_T: if (hs && (t_cnt == len_t_q - LTW'(1))) state_nx = DRAIN;
         DRAIN:    if (d_cnt == len_s_q) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------- config and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_s_q    <= '0;
         len_t_q    <= '0;
         match_q    <= '0;
         mismatch_q <= '0;
         gap_open_q <= '0;
         gap_ext_q  <= '0;
         s_cnt      <= '0;
         t_cnt      <= '0;
         d_cnt      <= '0;
      end else if (clr) begin
         len_s_q    <= len_s;
         len_t_q    <= len_t;
         match_q    <= match;
         mismatch_q <= mismatch;
         gap_open_q <= gap_open;
         gap_ext_q  <= gap_ext;
         s_cnt      <= '0;
         t_cnt      <= '0;
         d_cnt      <= '0;
      end else begin
         if (s_we)
            s_cnt <= s_cnt + LSW'(1);
         if ((state == STREAM_T) && hs)
            t_cnt <= t_cnt + LTW'(1);
         if (state == DRAIN)
            d_cnt <= d_cnt + LSW'(1);
      end
   end

   // ---------------------------------------------------------- PE array
   // Cell i holds S[i] and, per valid target symbol j, produces H/F for
   // column j plus the running column maximum over cells 0..i. Bubbles
   // (vin=0) travel with the wavefront and leave all cell state untouched.
   for (genvar i = 0; i < NPE; i++) begin : g_pe
      logic            vin;
      logic [SYMW-1:0] tin;
      logic [SW-1:0]   hup, fup, mup;
      logic            en;
      logic [SYMW-1:0] s_r, t_r;
      logic            v_r;
      logic [SW-1:0]   h_r, e_r, f_r, d_r, m_r;
      logic [SW-1:0]   h_nx, e_nx, f_nx, m_nx;
      logic signed [IW-1:0] dsc;

      if (i == 0) begin : g_head
         assign vin = inj_vld;
         assign tin = in_data;
         assign hup = '0;
         assign fup = '0;
         assign mup = '0;
      end else begin : g_tail
         assign vin = vld_bus[i-1];
         assign tin = sym_bus[i-1];
         assign hup = h_bus[i-1];
         assign fup = f_bus[i-1];
         assign mup = m_bus[i-1];
      end

      // Cells past the query length still compute but never feed the maximum.
      assign en = (LSW'(i) < len_s_q);

      always_comb begin
         e_nx = clip(smax(ext(h_r) - gop_s, ext(e_r) - gex_s));
         f_nx = clip(smax(ext(hup) - gop_s, ext(fup) - gex_s));
         dsc  = (s_r == tin) ? (ext(d_r) + mat_s) : (ext(d_r) - mis_s);
         h_nx = umax(umax(e_nx, f_nx), clip(dsc));
         m_nx = (en && (h_nx > mup)) ? h_nx : mup;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s_r <= '0;
            t_r <= '0;
            v_r <= 1'b0;
            h_r <= '0;
            e_r <= '0;
            f_r <= '0;
            d_r <= '0;
            m_r <= '0;
         end else begin
            if (s_we && (s_cnt == LSW'(i)))
               s_r <= in_data;
            if (clr) begin
               t_r <= '0;
               v_r <= 1'b0;
               h_r <= '0;
               e_r <= '0;
               f_r <= '0;
               d_r <= '0;
               m_r <= '0;
            end else begin
               v_r <= vin;
               t_r <= tin;
               if (vin) begin
                  h_r <= h_nx;
                  e_r <= e_nx;
                  f_r <= f_nx;
                  // Upstream H of this column is the diagonal for the next column.
                  d_r <= hup;
                  m_r <= m_nx;
               end
            end
         end
      end

      assign vld_bus[i] = v_r;
      assign sym_bus[i] = t_r;
      assign h_bus[i]   = h_r;
      assign f_bus[i]   = f_r;
      assign m_bus[i]   = m_r;
   end

   // Column maxima leave the last active cell in increasing j order, so a
   // strictly-greater update keeps the smallest column on equal scores.
   always_comb begin
      tap_vld = 1'b0;
      tap_m   = '0;
      for (int k = 0; k < NPE; k++) begin
         if (LSW'(k) == last_idx) begin
            tap_vld = vld_bus[k];
            tap_m   = m_bus[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         best    <= '0;
         best_j  <= '0;
         col_cnt <= '0;
      end else if (clr) begin
         best    <= '0;
         best_j  <= '0;
         col_cnt <= '0;
      end else if (tap_vld) begin
         col_cnt <= col_cnt + LTW'(1);
         if (tap_m > best) begin
            best   <= tap_m;
            best_j <= col_cnt;
         end
      end
   end

   // ------------------------------------------------------------ results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_score <= '0;
         max_end_t <= '0;
         err_q     <= 1'b0;
      end else if (clr) begin
         if (cfg_bad) begin
            max_score <= '0;
            max_end_t <= '0;
            err_q     <= 1'b1;
         end else begin
            err_q     <= 1'b0;
         end
      end else if ((state == DRAIN) && (d_cnt == len_s_q)) begin
         max_score <= best;
         max_end_t <= best_j;
      end
   end

endmodule

// File: tb/tb_sw_align_param.sv
// Bench for sw_align_param: directed jobs, expected results queued by the
// driver and checked by an independent monitor on every done pulse.
module tb_sw_align_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic [7:0] len_s;
   logic [9:0] len_t;
   logic [3:0] match, mismatch, gap_open, gap_ext;
   logic       in_valid;
   logic [1:0] in_data;

   logic       rdy_a, busy_a, done_a, err_a;
   logic [11:0] score_a;
   logic [9:0] end_a;
   logic       rdy_b, busy_b, done_b, err_b;
   logic [5:0] score_b;
   logic [9:0] end_b;

   typedef struct {
      int id;
      int score;
      int end_t;
      int err;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   s_vec[$];
   int   t_vec[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_done = 0;

   sw_align_param dut_a (
      .clk(clk), .reset(reset), .start(start_a), .len_s(len_s), .len_t(len_t),
      .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_ext(gap_ext),
      .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
      .busy(busy_a), .done(done_a), .err(err_a), .max_score(score_a), .max_end_t(end_a)
   );

   sw_align_param #(.NPE(64), .SW(6)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .len_s(len_s[6:0]), .len_t(len_t),
      .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_ext(gap_ext),
      .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
      .busy(busy_b), .done(done_b), .err(err_b), .max_score(score_b), .max_end_t(end_b)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit cur_rdy(input int id);
      return (id == 1) ? rdy_b : rdy_a;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_in_ready"}, int'(rdy_a), 0);
      chk({tag, "_busy"}, int'(busy_a), 0);
      chk({tag, "_done"}, int'(done_a), 0);
      chk({tag, "_err"}, int'(err_a), 0);
      chk({tag, "_max_score"}, int'(score_a), 0);
      chk({tag, "_max_end_t"}, int'(end_a), 0);
   endtask

   // Monitor: every done pulse consumes one expected result.
   initial begin
      forever begin
         exp_t e;
         int   id, sc, en, er;
         @(negedge clk);
         if (!reset && (done_a || done_b)) begin
            id = done_b ? 1 : 0;
            sc = (id == 1) ? int'(score_b) : int'(score_a);
            en = (id == 1) ? int'(end_b) : int'(end_a);
            er = (id == 1) ? int'(err_b) : int'(err_a);
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("dut_id", id, e.id);
               chk("max_score", sc, e.score);
               chk("max_end_t", en, e.end_t);
               chk("err", er, e.err);
               chk("done_cycle", cyc, e.cyc);
            end
            n_done++;
         end
      end
   end

   task automatic run_job(input int id, input int m, input int mm, input int go, input int ge,
                          input bit toggle, input bit hold_start, input int abort_after,
                          input int exp_score, input int exp_end);
      int   idx, guard, k, hs_cyc, target;
      bit   hs;
      exp_t e;
      len_s    = 8'(s_vec.size());
      len_t    = 10'(t_vec.size());
      match    = 4'(m);
      mismatch = 4'(mm);
      gap_open = 4'(go);
      gap_ext  = 4'(ge);
      if (id == 1) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < s_vec.size() && guard < 400) begin
         in_valid = 1'b1;
         in_data  = 2'(s_vec[idx]);
         hs = cur_rdy(id);
         @(posedge clk); #1;
         guard++;
         if (hs) idx++;
      end
      if (idx < s_vec.size()) chk("load_timeout", idx, s_vec.size());
      idx = 0;
      k = 0;
      hs_cyc = 0;
      while (idx < t_vec.size() && guard < 1200) begin
         in_valid = toggle ? ((k % 2) == 0) : 1'b1;
         in_data  = 2'(t_vec[idx]);
         if (hold_start) begin
            if (id == 1) start_b = 1'b1; else start_a = 1'b1;
         end
         hs = in_valid && cur_rdy(id);
         if (hs) hs_cyc = cyc;
         @(posedge clk); #1;
         k++;
         guard++;
         if (hs) begin
            idx++;
            if (idx == abort_after) begin
               reset    = 1'b1;
               start_a  = 1'b0;
               start_b  = 1'b0;
               in_valid = 1'b0;
               #2;
               check_zero("abort");
               @(posedge clk);
               @(posedge clk); #1;
               reset = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      if (idx < t_vec.size()) chk("stream_timeout", idx, t_vec.size());
      e = '{id, exp_score, exp_end, 0, hs_cyc + s_vec.size() + 2};
      exp_q.push_back(e);
      target = n_done + 1;
      guard = 0;
      while (n_done < target && guard < 500) begin
         @(posedge clk);
         guard++;
      end
      #1;
      if (n_done < target) chk("done_timeout", 0, 1);
   endtask

   task automatic run_err(input int ls, input int lt, input string nm);
      int   ever, target;
      exp_t e;
      len_s    = 8'(ls);
      len_t    = 10'(lt);
      start_a  = 1'b1;
      in_valid = 1'b1;
      e = '{0, 0, 0, 1, cyc + 1};
      exp_q.push_back(e);
      target = n_done + 1;
      @(posedge clk); #1;
      start_a = 1'b0;
      ever = 0;
      repeat (4) begin
         if (rdy_a) ever = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({nm, "_in_ready"}, ever, 0);
      if (n_done < target) chk({nm, "_done_missing"}, 0, 1);
   endtask

   initial begin
      reset    = 1'b1;
      start_a  = 1'b0;
      start_b  = 1'b0;
      len_s    = '0;
      len_t    = '0;
      match    = '0;
      mismatch = '0;
      gap_open = '0;
      gap_ext  = '0;
      in_valid = 1'b0;
      in_data  = '0;
      #3;
      check_zero("reset");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check_zero("idle");

      // Exact diagonal match: 4 * 2 = 8 ending at column 3.
      s_vec = '{0, 1, 2, 3};
      t_vec = '{0, 1, 2, 3};
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b0, -1, 8, 3);

      // No matching symbol anywhere.
      s_vec = '{0, 0, 0, 0};
      t_vec = '{1, 1, 1, 1};
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b0, -1, 0, 0);

      // Illegal configurations.
      run_err(0, 4, "len_s_zero");
      run_err(129, 4, "len_s_big");
      run_err(4, 0, "len_t_zero");

      // Same as the first job with bubbles on every other cycle.
      s_vec = '{0, 1, 2, 3};
      t_vec = '{0, 1, 2, 3};
      run_job(0, 2, 1, 2, 1, 1'b1, 1'b0, -1, 8, 3);

      // Score 4 reached at column 1 (row 1) and at column 2 (row 3): keep column 1.
      s_vec = '{0, 1, 2, 3};
      t_vec = '{0, 1, 3};
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b0, -1, 4, 1);

      // One extra target symbol bridged by a gap: 12 - 1 + 4 = 15 at column 4.
      s_vec = '{0, 1, 2, 3};
      t_vec = '{0, 1, 2, 1, 3};
      run_job(0, 4, 4, 1, 1, 1'b0, 1'b0, -1, 15, 4);

      // Saturation on the narrow instance: 2*(j+1) first exceeds 63 at column 31.
      s_vec.delete();
      t_vec.delete();
      for (int i = 0; i < 40; i++) begin
         s_vec.push_back(0);
         t_vec.push_back(0);
      end
      run_job(1, 2, 1, 2, 1, 1'b0, 1'b0, -1, 63, 31);

      // Reset in the middle of streaming, then a clean rerun.
      s_vec = '{0, 1, 2, 3};
      t_vec = '{0, 1, 2, 3};
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b0, 2, 0, 0);
      @(posedge clk); #1;
      check_zero("post_abort");
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b0, -1, 8, 3);

      // start held high while streaming must not restart the engine.
      run_job(0, 2, 1, 2, 1, 1'b0, 1'b1, -1, 8, 3);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_start_idle_busy", int'(busy_a), 0);
      chk("leftover_expected", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
